commit_rob: RTL and testbench

COMMIT_ROB -- requirements
Module: commit_rob

---
 rtl/commit_rob_if.sv | 34 +++
 rtl/commit_rob.sv | 160 ++++++++++++++++
 tb/tb_commit_rob.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/commit_rob_if.sv
// Commit ROB bus: dispatch requests/tags, writeback completions, retire writes and occupancy.
// master drives dispatch/writeback/flush; slave is the reorder buffer.
interface commit_rob_if #(
  parameter int TAG_W  = 3,
  parameter int WB_CH  = 3,
  parameter int PC_W   = 64,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64
);
  logic                      flush;
  logic [1:0]                disp_valid;
  logic [2*PC_W-1:0]         disp_pc;
  logic [2*ADDR_W-1:0]       disp_addr;
  logic                      disp_ready;
  logic [2*TAG_W-1:0]        disp_tag;
  logic [WB_CH-1:0]          wb_valid;
  logic [WB_CH*TAG_W-1:0]    wb_tag;
  logic [WB_CH*DATA_W-1:0]   wb_data;
  logic [1:0]                ret_wb_ena;
  logic [2*ADDR_W-1:0]       ret_wb_addr;
  logic [2*DATA_W-1:0]       ret_wb_data;
  logic [2*PC_W-1:0]         ret_pc;
  logic [TAG_W:0]            count;

  modport master (
    output flush, disp_valid, disp_pc, disp_addr, wb_valid, wb_tag, wb_data,
    input  disp_ready, disp_tag, ret_wb_ena, ret_wb_addr, ret_wb_data, ret_pc, count
  );

  modport slave (
    input  flush, disp_valid, disp_pc, disp_addr, wb_valid, wb_tag, wb_data,
    output disp_ready, disp_tag, ret_wb_ena, ret_wb_addr, ret_wb_data, ret_pc, count
  );
endinterface

// File: rtl/commit_rob.sv
// Dual-dispatch, dual-retire in-order commit reorder buffer with WB_CH writeback channels.
// Define COMMIT_ROB_WB_BYPASS_EN to let a same-cycle writeback on head/head+1 retire at that edge.
module commit_rob #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 3,
  parameter int WB_CH  = 3,
  parameter int PC_W   = 64,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64
) (
  input logic         clk,
  input logic         rst,
  commit_rob_if.slave bus
);
  localparam int CW = TAG_W + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DEPTH-1:0]    valid_q, valid_d, done_q, done_d;
  logic [PC_W-1:0]     pc_q   [DEPTH];
  logic [PC_W-1:0]     pc_d   [DEPTH];
  logic [ADDR_W-1:0]   addr_q [DEPTH];
  logic [ADDR_W-1:0]   addr_d [DEPTH];
  logic [DATA_W-1:0]   data_q [DEPTH];
  logic [DATA_W-1:0]   data_d [DEPTH];
  logic [TAG_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]       count_q, count_d;
  logic [1:0]          ret_wb_ena_q, ret_wb_ena_d;
  logic [2*ADDR_W-1:0] ret_wb_addr_q, ret_wb_addr_d;
  logic [2*DATA_W-1:0] ret_wb_data_q, ret_wb_data_d;
  logic [2*PC_W-1:0]   ret_pc_q, ret_pc_d;

  logic                disp_ready;
  logic [1:0]          alloc_ok;
  logic [TAG_W-1:0]    alloc_tag [2];
  logic [TAG_W-1:0]    slot_tag  [2];
  logic [1:0]          slot_done;
  logic [DATA_W-1:0]   slot_data [2];
  logic [1:0]          ret_ok;

  // Readiness uses the pre-edge count; channel 1 compacts onto tail when channel 0 is idle.
  assign disp_ready   = (DEPTH_C - count_q) >= CW'(2);
  assign alloc_ok     = disp_ready ? bus.disp_valid : 2'b00;
  assign alloc_tag[0] = tail_q;
  assign alloc_tag[1] = tail_q + TAG_W'(bus.disp_valid[0]);
  assign slot_tag[0]  = head_q;
  assign slot_tag[1]  = head_q + TAG_W'(1);

  assign bus.disp_ready  = disp_ready;
  assign bus.disp_tag    = {alloc_tag[1], alloc_tag[0]};
  assign bus.count       = count_q;
  assign bus.ret_wb_ena  = ret_wb_ena_q;
  assign bus.ret_wb_addr = ret_wb_addr_q;
  assign bus.ret_wb_data = ret_wb_data_q;
  assign bus.ret_pc      = ret_pc_q;

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      slot_done[s] = done_q[slot_tag[s]];
      slot_data[s] = data_q[slot_tag[s]];
`ifdef COMMIT_ROB_WB_BYPASS_EN
      // Later channels override earlier ones, matching the registered writeback priority.
      for (int i = 0; i < WB_CH; i++) begin
        if (bus.wb_valid[i] && (bus.wb_tag[i*TAG_W +: TAG_W] == slot_tag[s])) begin
          slot_done[s] = 1'b1;
          slot_data[s] = bus.wb_data[i*DATA_W +: DATA_W];
        end
      end
`endif
    end
    ret_ok[0] = valid_q[slot_tag[0]] & slot_done[0];
    ret_ok[1] = ret_ok[0] & valid_q[slot_tag[1]] & slot_done[1];
  end

  always_comb begin
    valid_d       = valid_q;
    done_d        = done_q;
    pc_d          = pc_q;
    addr_d        = addr_q;
    data_d        = data_q;
    head_d        = head_q + TAG_W'(ret_ok[0]) + TAG_W'(ret_ok[1]);
    tail_d        = tail_q + TAG_W'(alloc_ok[0]) + TAG_W'(alloc_ok[1]);
    count_d       = count_q + CW'(alloc_ok[0]) + CW'(alloc_ok[1])
                  - CW'(ret_ok[0]) - CW'(ret_ok[1]);
    ret_wb_ena_d  = '0;
    ret_wb_addr_d = '0;
    ret_wb_data_d = '0;
    ret_pc_d      = '0;

    for (int i = 0; i < WB_CH; i++) begin
      if (bus.wb_valid[i] && valid_q[bus.wb_tag[i*TAG_W +: TAG_W]]) begin
        done_d[bus.wb_tag[i*TAG_W +: TAG_W]] = 1'b1;
        data_d[bus.wb_tag[i*TAG_W +: TAG_W]] = bus.wb_data[i*DATA_W +: DATA_W];
      end
    end

    // Retiring entries are always valid and allocations always target free ones, so no overlap.
    for (int s = 0; s < 2; s++) begin
      if (ret_ok[s]) begin
        valid_d[slot_tag[s]]               = 1'b0;
        done_d[slot_tag[s]]                = 1'b0;
        ret_wb_ena_d[s]                    = (addr_q[slot_tag[s]] != '0);
        ret_wb_addr_d[s*ADDR_W +: ADDR_W]  = addr_q[slot_tag[s]];
        ret_wb_data_d[s*DATA_W +: DATA_W]  = slot_data[s];
        ret_pc_d[s*PC_W +: PC_W]           = pc_q[slot_tag[s]];
      end
    end

    for (int c = 0; c < 2; c++) begin
      if (alloc_ok[c]) begin
        valid_d[alloc_tag[c]] = 1'b1;
        done_d[alloc_tag[c]]  = 1'b0;
        pc_d[alloc_tag[c]]    = bus.disp_pc[c*PC_W +: PC_W];
        addr_d[alloc_tag[c]]  = bus.disp_addr[c*ADDR_W +: ADDR_W];
      end
    end

    if (bus.flush) begin
      valid_d       = '0;
      done_d        = '0;
      head_d        = '0;
      tail_d        = '0;
      count_d       = '0;
      ret_wb_ena_d  = '0;
      ret_wb_addr_d = '0;
      ret_wb_data_d = '0;
      ret_pc_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= '0;
      done_q        <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      ret_wb_ena_q  <= '0;
      ret_wb_addr_q <= '0;
      ret_wb_data_q <= '0;
      ret_pc_q      <= '0;
    end else begin
      valid_q       <= valid_d;
      done_q        <= done_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      ret_wb_ena_q  <= ret_wb_ena_d;
      ret_wb_addr_q <= ret_wb_addr_d;
      ret_wb_data_q <= ret_wb_data_d;
      ret_pc_q      <= ret_pc_d;
    end
  end

  // Payload is qualified by valid, so it needs no reset.
  always_ff @(posedge clk) begin
    pc_q   <= pc_d;
    addr_q <= addr_d;
    data_q <= data_d;
  end
endmodule

// File: tb/tb_commit_rob.sv
// Bench for commit_rob: directed scenarios plus randomized traffic compared against
// an in-order queue model of the reorder buffer.
`timescale 1ns/1ps
module tb_commit_rob;
  localparam int DEPTH = 8, TAG_W = 3, WB_CH = 3, PC_W = 64, ADDR_W = 5, DATA_W = 64;
`ifdef COMMIT_ROB_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    int                tag;
    logic [PC_W-1:0]   pc;
    logic [ADDR_W-1:0] addr;
    bit                done;
    logic [DATA_W-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail = 0;

  ent_t                rob[$];
  int                  next_tag = 0;
  logic [1:0]          exp_ena;
  logic [2*ADDR_W-1:0] exp_addr;
  logic [2*DATA_W-1:0] exp_data;
  logic [2*PC_W-1:0]   exp_pc;

  commit_rob_if #(.TAG_W(TAG_W), .WB_CH(WB_CH), .PC_W(PC_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  commit_rob #(.DEPTH(DEPTH), .TAG_W(TAG_W), .WB_CH(WB_CH), .PC_W(PC_W), .ADDR_W(ADDR_W),
               .DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic idle();
    rst            = 1'b0;
    bus.flush      = 1'b0;
    bus.disp_valid = '0;
    bus.disp_pc    = '0;
    bus.disp_addr  = '0;
    bus.wb_valid   = '0;
    bus.wb_tag     = '0;
    bus.wb_data    = '0;
  endtask

  task automatic set_disp(input logic [1:0] v, input logic [PC_W-1:0] p0, input logic [ADDR_W-1:0] a0,
                          input logic [PC_W-1:0] p1, input logic [ADDR_W-1:0] a1);
    bus.disp_valid = v;
    bus.disp_pc    = {p1, p0};
    bus.disp_addr  = {a1, a0};
  endtask

  task automatic set_wb(input int ch, input int tag, input logic [DATA_W-1:0] d);
    bus.wb_valid[ch]                 = 1'b1;
    bus.wb_tag[ch*TAG_W +: TAG_W]    = TAG_W'(tag);
    bus.wb_data[ch*DATA_W +: DATA_W] = d;
  endtask

  // Reference: ROB as an ordered list; retire pops the oldest done entries, up to two.
  task automatic model_step();
    ent_t post[$];
    ent_t src[$];
    int   n;
    bit   ready;
    exp_ena = '0; exp_addr = '0; exp_data = '0; exp_pc = '0;
    if (rst || bus.flush) begin
      rob.delete();
      next_tag = 0;
      return;
    end
    ready = (DEPTH - rob.size()) >= 2;
    post = rob;
    for (int i = 0; i < WB_CH; i++)
      if (bus.wb_valid[i])
        foreach (post[j])
          if (post[j].tag == int'(bus.wb_tag[i*TAG_W +: TAG_W])) begin
            post[j].done = 1'b1;
            post[j].data = bus.wb_data[i*DATA_W +: DATA_W];
          end
    if (BYPASS) src = post;
    else        src = rob;
    n = 0;
    if (src.size() > 0 && src[0].done) begin
      n = 1;
      if (src.size() > 1 && src[1].done) n = 2;
    end
    for (int k = 0; k < n; k++) begin
      exp_ena[k]                    = (src[k].addr != 0);
      exp_addr[k*ADDR_W +: ADDR_W]  = src[k].addr;
      exp_data[k*DATA_W +: DATA_W]  = src[k].data;
      exp_pc[k*PC_W +: PC_W]        = src[k].pc;
    end
    rob = post;
    for (int k = 0; k < n; k++) void'(rob.pop_front());
    if (ready)
      for (int c = 0; c < 2; c++)
        if (bus.disp_valid[c]) begin
          ent_t e;
          e.tag  = next_tag;
          e.pc   = bus.disp_pc[c*PC_W +: PC_W];
          e.addr = bus.disp_addr[c*ADDR_W +: ADDR_W];
          e.done = 1'b0;
          e.data = '0;
          rob.push_back(e);
          next_tag = (next_tag + 1) % DEPTH;
        end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_disp(2'b11, 64'h10, 5'd1, 64'h14, 5'd2);
    tick();
    rst = 1'b1;
    tick();
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.count); end
    n_checks++; if (bus.disp_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %0b expected 1", bus.disp_ready); end
    n_checks++; if ({bus.ret_wb_ena, bus.ret_wb_addr, bus.ret_wb_data, bus.ret_pc} !== '0) begin
      n_fail++; $display("[TB] FAIL reset_ret: got ena %0b pc %0h expected all zero", bus.ret_wb_ena, bus.ret_pc); end
  endtask

  task automatic test_basic();
    rst = 1'b1; tick();
    set_disp(2'b11, 64'h8000_0000, 5'd5, 64'h8000_0004, 5'd6);
    #1;
    n_checks++; if (bus.disp_tag !== {3'd1, 3'd0}) begin n_fail++; $display("[TB] FAIL basic_tags: got %0h expected 8", bus.disp_tag); end
    tick();
    n_checks++; if (bus.count !== 4'd2) begin n_fail++; $display("[TB] FAIL basic_count: got %0d expected 2", bus.count); end
    set_wb(0, 1, 64'h22); tick();
    set_wb(0, 0, 64'h11); tick();
    if (!BYPASS) tick();
    n_checks++; if (bus.ret_wb_ena !== 2'b11) begin n_fail++; $display("[TB] FAIL basic_ena: got %0b expected 11", bus.ret_wb_ena); end
    n_checks++; if (bus.ret_wb_addr !== {5'd6, 5'd5}) begin n_fail++; $display("[TB] FAIL basic_addr: got %0h expected %0h", bus.ret_wb_addr, {5'd6, 5'd5}); end
    n_checks++; if (bus.ret_wb_data !== {64'h22, 64'h11}) begin n_fail++; $display("[TB] FAIL basic_data: got %0h expected 22_11", bus.ret_wb_data); end
    n_checks++; if (bus.ret_pc !== {64'h8000_0004, 64'h8000_0000}) begin n_fail++; $display("[TB] FAIL basic_pc: got %0h", bus.ret_pc); end
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("[TB] FAIL basic_count_after: got %0d expected 0", bus.count); end
    tick();
    n_checks++; if (bus.ret_wb_ena !== 2'b00) begin n_fail++; $display("[TB] FAIL basic_ena_pulse: got %0b expected 00", bus.ret_wb_ena); end
  endtask

  task automatic test_full();
    rst = 1'b1; tick();
    for (int k = 0; k < 4; k++) begin
      set_disp(2'b11, 64'(32'h100 + 8*k), ADDR_W'(2*k+1), 64'(32'h104 + 8*k), ADDR_W'(2*k+2));
      tick();
    end
    n_checks++; if (bus.count !== 4'd8) begin n_fail++; $display("[TB] FAIL full_count8: got %0d expected 8", bus.count); end
    n_checks++; if (bus.disp_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL full_ready8: got %0b expected 0", bus.disp_ready); end
    set_disp(2'b11, 64'h900, 5'd9, 64'h904, 5'd10); tick();
    n_checks++; if (bus.count !== 4'd8) begin n_fail++; $display("[TB] FAIL full_ignored8: got %0d expected 8", bus.count); end
    set_wb(0, 0, 64'h100); tick(); tick(); tick();
    n_checks++; if (bus.count !== 4'd7) begin n_fail++; $display("[TB] FAIL full_count7: got %0d expected 7", bus.count); end
    n_checks++; if (bus.disp_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL full_ready7: got %0b expected 0", bus.disp_ready); end
    set_disp(2'b01, 64'h908, 5'd11, 64'h0, 5'd0); tick();
    n_checks++; if (bus.count !== 4'd7) begin n_fail++; $display("[TB] FAIL full_ignored7: got %0d expected 7", bus.count); end
    set_wb(1, 1, 64'h101); tick(); tick(); tick();
    n_checks++; if (bus.disp_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL full_ready6: got %0b expected 1", bus.disp_ready); end
    set_disp(2'b11, 64'hA00, 5'd12, 64'hA04, 5'd13);
    #1;
    n_checks++; if (bus.disp_tag !== {3'd1, 3'd0}) begin n_fail++; $display("[TB] FAIL full_wrap_tags: got %0h expected 8", bus.disp_tag); end
    tick();
    n_checks++; if (bus.count !== 4'd8) begin n_fail++; $display("[TB] FAIL full_refill: got %0d expected 8", bus.count); end
  endtask

  task automatic test_addr_zero();
    rst = 1'b1; tick();
    set_disp(2'b01, 64'h1000, 5'd0, 64'h0, 5'd0); tick();
    n_checks++; if (bus.count !== 4'd1) begin n_fail++; $display("[TB] FAIL zero_count1: got %0d expected 1", bus.count); end
    set_wb(2, 0, 64'h55); tick();
    if (!BYPASS) tick();
    n_checks++; if (bus.ret_wb_ena !== 2'b00) begin n_fail++; $display("[TB] FAIL zero_ena: got %0b expected 00", bus.ret_wb_ena); end
    n_checks++; if (bus.ret_pc[PC_W-1:0] !== 64'h1000) begin n_fail++; $display("[TB] FAIL zero_pc: got %0h expected 1000", bus.ret_pc[PC_W-1:0]); end
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("[TB] FAIL zero_count0: got %0d expected 0", bus.count); end
  endtask

  task automatic test_wb_conflict();
    bit                seen;
    logic [DATA_W-1:0] seen_data;
    rst = 1'b1; tick();
    set_disp(2'b11, 64'h200, 5'd1, 64'h204, 5'd2); tick();
    set_disp(2'b11, 64'h208, 5'd3, 64'h20C, 5'd13); tick();
    seen = 1'b0; seen_data = '0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (cyc == 0) begin set_wb(0, 3, 64'hAA); set_wb(1, 0, 64'h10); set_wb(2, 3, 64'hBB); end
      if (cyc == 1) begin set_wb(0, 1, 64'h11); set_wb(1, 2, 64'h12); set_wb(2, 5, 64'hEE); end
      tick();
      for (int s = 0; s < 2; s++)
        if (bus.ret_wb_ena[s] && bus.ret_wb_addr[s*ADDR_W +: ADDR_W] == 5'd13) begin
          seen = 1'b1;
          seen_data = bus.ret_wb_data[s*DATA_W +: DATA_W];
        end
    end
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("[TB] FAIL conflict_retired: got %0b expected 1", seen); end
    n_checks++; if (seen_data !== 64'hBB) begin n_fail++; $display("[TB] FAIL conflict_data: got %0h expected bb", seen_data); end
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("[TB] FAIL conflict_count: got %0d expected 0", bus.count); end
    set_disp(2'b11, 64'h300, 5'd20, 64'h304, 5'd21); tick();
    set_wb(0, 4, 64'h44); tick(); tick(); tick();
    n_checks++; if (bus.count !== 4'd1) begin n_fail++; $display("[TB] FAIL stale_wb_count: got %0d expected 1", bus.count); end
  endtask

  task automatic test_flush();
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin rst = 1'b1; tick(); set_disp(2'b11, 64'h400, 5'd1, 64'h404, 5'd2); tick(); end
      set_disp(2'b11, 64'h408, 5'd3, 64'h40C, 5'd4); tick();
      set_wb(0, 1, 64'h1); set_wb(1, 2, 64'h2); set_wb(2, 3, 64'h3); tick();
      tick();
      n_checks++; if (bus.count !== 4'd4) begin n_fail++; $display("[TB] FAIL flush_pre_count%0d: got %0d expected 4", pass, bus.count); end
      if (pass == 0) bus.flush = 1'b1;
      else           rst = 1'b1;
      set_wb(0, 0, 64'h99);
      set_disp(2'b11, 64'h500, 5'd7, 64'h504, 5'd8);
      tick();
      n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("[TB] FAIL flush_count%0d: got %0d expected 0", pass, bus.count); end
      n_checks++; if (bus.ret_wb_ena !== 2'b00) begin n_fail++; $display("[TB] FAIL flush_ena%0d: got %0b expected 00", pass, bus.ret_wb_ena); end
      n_checks++; if (bus.disp_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_ready%0d: got %0b expected 1", pass, bus.disp_ready); end
      set_disp(2'b11, 64'h600, 5'd9, 64'h604, 5'd10);
      #1;
      n_checks++; if (bus.disp_tag !== {3'd1, 3'd0}) begin n_fail++; $display("[TB] FAIL flush_tags%0d: got %0h expected 8", pass, bus.disp_tag); end
      tick();
    end
  endtask

  task automatic test_latency();
    rst = 1'b1; tick();
    set_disp(2'b01, 64'h2000, 5'd7, 64'h0, 5'd0); tick();
    set_wb(1, 0, 64'h77); tick();
    n_checks++; if (bus.ret_wb_ena[0] !== BYPASS) begin n_fail++; $display("[TB] FAIL latency_first: got %0b expected %0b", bus.ret_wb_ena[0], BYPASS); end
    tick();
    n_checks++; if (bus.ret_wb_ena[0] !== !BYPASS) begin n_fail++; $display("[TB] FAIL latency_second: got %0b expected %0b", bus.ret_wb_ena[0], !BYPASS); end
  endtask

  task automatic test_random();
    bit ready_exp;
    rst = 1'b1; tick();
    for (int cyc = 0; cyc < 400; cyc++) begin
      set_disp(2'($urandom), {$urandom, $urandom}, ADDR_W'($urandom), {$urandom, $urandom}, ADDR_W'($urandom));
      for (int ch = 0; ch < WB_CH; ch++)
        if ($urandom_range(1) == 1) begin
          if (rob.size() > 0 && $urandom_range(3) != 0)
            set_wb(ch, rob[$urandom_range(rob.size()-1)].tag, {$urandom, $urandom});
          else
            set_wb(ch, $urandom_range(DEPTH-1), {$urandom, $urandom});
        end
      bus.flush = ($urandom_range(31) == 0);
      rst       = ($urandom_range(63) == 0);
      #1;
      ready_exp = (DEPTH - rob.size()) >= 2;
      n_checks++; if (bus.disp_ready !== ready_exp) begin n_fail++; $display("[TB] FAIL rand_ready c%0d: got %0b expected %0b", cyc, bus.disp_ready, ready_exp); end
      if (bus.disp_valid[0]) begin
        n_checks++; if (int'(bus.disp_tag[TAG_W-1:0]) !== next_tag) begin n_fail++; $display("[TB] FAIL rand_tag0 c%0d: got %0d expected %0d", cyc, bus.disp_tag[TAG_W-1:0], next_tag); end
      end
      if (bus.disp_valid[1]) begin
        n_checks++; if (int'(bus.disp_tag[2*TAG_W-1:TAG_W]) !== (next_tag + int'(bus.disp_valid[0])) % DEPTH) begin
          n_fail++; $display("[TB] FAIL rand_tag1 c%0d: got %0d expected %0d", cyc, bus.disp_tag[2*TAG_W-1:TAG_W], (next_tag + int'(bus.disp_valid[0])) % DEPTH); end
      end
      tick();
      n_checks++; if (int'(bus.count) !== rob.size()) begin n_fail++; $display("[TB] FAIL rand_count c%0d: got %0d expected %0d", cyc, bus.count, rob.size()); end
      n_checks++; if (bus.ret_wb_ena !== exp_ena) begin n_fail++; $display("[TB] FAIL rand_ena c%0d: got %0b expected %0b", cyc, bus.ret_wb_ena, exp_ena); end
      n_checks++; if (bus.ret_wb_addr !== exp_addr) begin n_fail++; $display("[TB] FAIL rand_addr c%0d: got %0h expected %0h", cyc, bus.ret_wb_addr, exp_addr); end
      n_checks++; if (bus.ret_pc !== exp_pc) begin n_fail++; $display("[TB] FAIL rand_pc c%0d: got %0h expected %0h", cyc, bus.ret_pc, exp_pc); end
      for (int s = 0; s < 2; s++)
        if (exp_ena[s]) begin
          n_checks++; if (bus.ret_wb_data[s*DATA_W +: DATA_W] !== exp_data[s*DATA_W +: DATA_W]) begin
            n_fail++; $display("[TB] FAIL rand_data%0d c%0d: got %0h expected %0h", s, cyc, bus.ret_wb_data[s*DATA_W +: DATA_W], exp_data[s*DATA_W +: DATA_W]); end
        end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idle();
    test_reset();
    test_basic();
    test_full();
    test_addr_zero();
    test_wb_conflict();
    test_flush();
    test_latency();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
